// File: rtl/multi_acc_sat.sv
// Multi-channel signed accumulator with wrap/saturate arithmetic and per-channel
// sticky overflow. Two-stage pipeline: operand capture, then accumulate + output.
module multi_acc_sat #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int CHANNELS   = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1,
    localparam int CH_W      = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic                  signal_sat,
    input  logic [CH_W-1:0]       chan_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    input  logic                  signal_oe,
    output logic [CH_W-1:0]       chan_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  valid_out
);

    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Accumulator state
    logic [DATA_WIDTH-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]   sticky;

    // Stage 1 (operand capture)
    logic                  s1_valid;
    logic [CH_W-1:0]       s1_chan;
    logic                  s1_init;
    logic                  s1_sat;
    logic                  s1_neg_min;
    logic                  s1_seed;
    logic [DATA_WIDTH-1:0] s1_ext;

    logic                  chan_ok;
    assign chan_ok = ({1'b0, chan_in} < (CH_W+1)'(CHANNELS));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_chan    <= '0;
            s1_init    <= 1'b0;
            s1_sat     <= 1'b0;
            s1_neg_min <= 1'b0;
            s1_seed    <= 1'b0;
            s1_ext     <= '0;
        end else begin
            s1_valid   <= signal_load && chan_ok;
            s1_chan    <= chan_in;
            s1_init    <= signal_init;
            s1_sat     <= signal_sat;
            s1_neg_min <= signal_neg && (data_in == MIN_VAL);
            s1_seed    <= attr_in[OVERFLOW];
            s1_ext     <= signal_neg ? -data_in : data_in;
        end
    end

    // Stage 2 arithmetic; acc[] already holds any write from the previous cycle
    logic [DATA_WIDTH-1:0] acc_a;
    logic [DATA_WIDTH:0]   sum;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] new_acc;
    logic                  new_sticky;
    logic [ATTR_WIDTH-1:0] new_attr;

    always_comb begin
        acc_a      = s1_init ? '0 : acc[s1_chan];
        sum        = {acc_a[DATA_WIDTH-1], acc_a} + {s1_ext[DATA_WIDTH-1], s1_ext};
        // Sign-extended sum disagreeing in its top two bits == same-sign operands flipped sign
        ovf        = (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) || s1_neg_min;
        new_acc    = sum[DATA_WIDTH-1:0];
        if (s1_sat && ovf) begin
            new_acc = (s1_neg_min || !s1_ext[DATA_WIDTH-1]) ? MAX_VAL : MIN_VAL;
        end
        new_sticky = s1_init ? (s1_seed | ovf) : (sticky[s1_chan] | ovf);
        new_attr           = '0;
        new_attr[SIGN]     = new_acc[DATA_WIDTH-1];
        new_attr[OVERFLOW] = new_sticky;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            sticky <= '0;
        end else if (s1_valid) begin
            acc[s1_chan]    <= new_acc;
            sticky[s1_chan] <= new_sticky;
        end
    end

    // valid_out is a one-cycle strobe per accepted load with no back-pressure;
    // data/attr/chan are meaningful only while it is high and read as 0 when oe is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            attr_out  <= '0;
            chan_out  <= '0;
            valid_out <= 1'b0;
        end else if (!signal_oe) begin
            data_out  <= '0;
            attr_out  <= '0;
            chan_out  <= '0;
            valid_out <= 1'b0;
        end else if (s1_valid) begin
            data_out  <= new_acc;
            attr_out  <= new_attr;
            chan_out  <= s1_chan;
            valid_out <= 1'b1;
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_acc_sat.sv
// Bench for multi_acc_sat: directed literal scenarios plus randomized traffic
// checked every cycle against an integer-arithmetic reference model.
module tb_multi_acc_sat;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          signal_load = 1'b0;
    logic          signal_init = 1'b0;
    logic          signal_neg  = 1'b0;
    logic          signal_sat  = 1'b0;
    logic [1:0]    chan_in     = '0;
    logic [DW-1:0] data_in     = '0;
    logic [AW-1:0] attr_in     = '0;
    logic          signal_oe   = 1'b1;
    logic [1:0]    chan_out;
    logic [DW-1:0] data_out;
    logic [AW-1:0] attr_out;
    logic          valid_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    multi_acc_sat #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .CHANNELS(CH), .SIGN(0), .OVERFLOW(1)) dut (
        .clk(clk), .rst(rst), .signal_load(signal_load), .signal_init(signal_init),
        .signal_neg(signal_neg), .signal_sat(signal_sat), .chan_in(chan_in),
        .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
        .chan_out(chan_out), .data_out(data_out), .attr_out(attr_out), .valid_out(valid_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // reference model: integer arithmetic, an op is accepted at one edge and
    // lands (with oe sampled) at the following edge
    int         m_acc [CH];
    bit         m_sticky [CH];
    bit         p_valid = 0;
    int         p_ch;
    bit         p_init, p_neg, p_sat, p_seed;
    logic [7:0] p_data;
    logic [7:0] exp_data  = '0;
    logic [3:0] exp_attr  = '0;
    logic [1:0] exp_chan  = '0;
    logic       exp_valid = 1'b0;
    int         a, v, sum, res;
    bit         neg_min, ovf, st;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i]    = 0;
                m_sticky[i] = 0;
            end
            p_valid = 0;
            exp_data = '0; exp_attr = '0; exp_chan = '0; exp_valid = 1'b0;
        end else begin
            if (p_valid) begin
                a = p_init ? 0 : m_acc[p_ch];
                v = $signed(p_data);
                if (p_neg) v = -v;
                sum = a + v;
                neg_min = p_neg && (p_data == 8'h80);
                ovf = neg_min || (sum > 127) || (sum < -128);
                if (p_sat && ovf)
                    res = (neg_min || sum > 127) ? 127 : -128;
                else begin
                    res = (sum + 512) % 256;
                    if (res > 127) res = res - 256;
                end
                st = p_init ? (p_seed | ovf) : (m_sticky[p_ch] | ovf);
                m_acc[p_ch]    = res;
                m_sticky[p_ch] = st;
                if (signal_oe) begin
                    exp_data  = res[7:0];
                    exp_attr  = {2'b00, st, (res < 0)};
                    exp_chan  = p_ch[1:0];
                    exp_valid = 1'b1;
                end else begin
                    exp_data = '0; exp_attr = '0; exp_chan = '0; exp_valid = 1'b0;
                end
            end else begin
                exp_valid = 1'b0;
                if (!signal_oe) begin
                    exp_data = '0; exp_attr = '0; exp_chan = '0;
                end
            end
            p_valid = signal_load && (int'(chan_in) < CH);
            p_ch    = int'(chan_in);
            p_init  = signal_init;
            p_neg   = signal_neg;
            p_sat   = signal_sat;
            p_seed  = attr_in[1];
            p_data  = data_in;
        end
    end

    // scoreboard compare, every cycle, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_valid_out", valid_out, exp_valid);
            chk("model_data_out",  data_out,  exp_data);
            chk("model_attr_out",  attr_out,  exp_attr);
            chk("model_chan_out",  chan_out,  exp_chan);
        end
    end

    // driver: inputs change just after a falling edge
    task automatic drive(input bit ld, input bit init, input bit neg, input bit sat,
                         input logic [1:0] ch, input logic [7:0] d);
        @(negedge clk);
        signal_load = ld;
        signal_init = init;
        signal_neg  = neg;
        signal_sat  = sat;
        chan_in     = ch;
        data_in     = d;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic lit(input string name, input logic [7:0] d, input logic [3:0] at,
                       input logic [1:0] ch, input logic vld);
        chk({name, "_valid"}, valid_out, vld);
        chk({name, "_data"},  data_out,  d);
        chk({name, "_attr"},  attr_out,  at);
        chk({name, "_chan"},  chan_out,  ch);
    endtask

    initial begin
        attr_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1;
        lit("reset", 8'h00, 4'h0, 2'd0, 1'b0);

        // T1: basic add, latency 2
        drive(1, 1, 0, 0, 2'd0, 8'd5);
        drive(1, 0, 0, 0, 2'd0, 8'd3);
        chk("t1_no_early_valid", valid_out, 1'b0);
        idle(); lit("t1_a", 8'd5, 4'h0, 2'd0, 1'b1);
        idle(); lit("t1_b", 8'd8, 4'h0, 2'd0, 1'b1);

        // T2: wrap with sticky overflow, cleared by init
        drive(1, 1, 0, 0, 2'd1, 8'd100);
        drive(1, 0, 0, 0, 2'd1, 8'd50);
        drive(1, 0, 0, 0, 2'd1, 8'd1);   lit("t2_a", 8'h64, 4'h0, 2'd1, 1'b1);
        drive(1, 1, 0, 0, 2'd1, 8'd0);   lit("t2_b", 8'h96, 4'h3, 2'd1, 1'b1);
        idle();                          lit("t2_c", 8'h97, 4'h3, 2'd1, 1'b1);
        idle();                          lit("t2_d", 8'h00, 4'h0, 2'd1, 1'b1);

        // T3: saturation, including negate of the most negative value
        drive(1, 1, 0, 1, 2'd2, 8'd100);
        drive(1, 0, 0, 1, 2'd2, 8'd50);
        drive(1, 1, 0, 1, 2'd3, 8'h9C);  lit("t3_a", 8'h64, 4'h0, 2'd2, 1'b1);
        drive(1, 0, 1, 1, 2'd3, 8'd50);  lit("t3_b", 8'h7F, 4'h2, 2'd2, 1'b1);
        drive(1, 1, 1, 1, 2'd3, 8'h80);  lit("t3_c", 8'h9C, 4'h1, 2'd3, 1'b1);
        idle();                          lit("t3_d", 8'h80, 4'h3, 2'd3, 1'b1);
        idle();                          lit("t3_e", 8'h7F, 4'h2, 2'd3, 1'b1);

        // T4: interleaved back-to-back channels
        drive(1, 1, 0, 0, 2'd0, 8'd1);
        drive(1, 1, 0, 0, 2'd1, 8'd2);
        drive(1, 0, 0, 0, 2'd0, 8'd4);   lit("t4_a", 8'd1,  4'h0, 2'd0, 1'b1);
        drive(1, 0, 0, 0, 2'd1, 8'd8);   lit("t4_b", 8'd2,  4'h0, 2'd1, 1'b1);
        idle();                          lit("t4_c", 8'd5,  4'h0, 2'd0, 1'b1);
        idle();                          lit("t4_d", 8'd10, 4'h0, 2'd1, 1'b1);

        // T5: output enable low still updates the accumulator
        drive(1, 1, 0, 0, 2'd0, 8'd0);
        idle(); idle();
        signal_oe = 1'b0;
        drive(1, 0, 0, 0, 2'd0, 8'd1);
        drive(1, 0, 0, 0, 2'd0, 8'd1);
        idle();                          lit("t5_oe_a", 8'd0, 4'h0, 2'd0, 1'b0);
        idle();                          lit("t5_oe_b", 8'd0, 4'h0, 2'd0, 1'b0);
        signal_oe = 1'b1;
        drive(1, 0, 0, 0, 2'd0, 8'd0);
        idle(); idle();                  lit("t5_c", 8'd2, 4'h0, 2'd0, 1'b1);

        // T6: reset discards a load already in stage 1
        drive(1, 1, 0, 0, 2'd0, 8'd7);
        idle();
        rst = 1'b1;
        idle();                          chk("t6_rst_valid", valid_out, 1'b0);
        rst = 1'b0;
        idle();                          chk("t6_post_valid", valid_out, 1'b0);
        drive(1, 0, 0, 0, 2'd0, 8'd0);
        idle(); idle();                  lit("t6_a", 8'd0, 4'h0, 2'd0, 1'b1);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 199) == 0);
            signal_oe   = ($urandom_range(0, 9) != 0);
            signal_load = ($urandom_range(0, 9) < 7);
            signal_init = ($urandom_range(0, 4) == 0);
            signal_neg  = $urandom_range(0, 1) == 1;
            signal_sat  = $urandom_range(0, 1) == 1;
            chan_in     = 2'($urandom_range(0, 3));
            attr_in     = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0:       data_in = 8'h80;
                1:       data_in = 8'h7F;
                2:       data_in = 8'h00;
                default: data_in = 8'($urandom_range(0, 255));
            endcase
        end
        rst = 1'b0;
        signal_oe = 1'b1;
        repeat (4) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
